// File: rtl/int_gen_responder.sv
// int_gen_responder: device end of the bridge's write-only interrupt-generator
// channel. A 16-byte register window (CTRL, PERIOD, COUNT, STAT/ACK) programs a
// down-counter that sets PEND on expiry. irq drives HWInt[2].
// Build option: define INT_GEN_PULSE_EN to make irq a one-cycle pulse after
// each expiry instead of a level that follows PEND.
//
// Bus handshake: there is no valid/ready. Every cycle with byteen != 0 and
// addr[31:4] == BASE[31:4] is a write that commits on the next rising edge.
// rdata is a purely combinational read of the register picked by addr[3:2].
module int_gen_responder #(
  parameter logic [31:0] BASE  = 32'h0000_7F20,
  parameter int          CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               en_q, en_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pend_q, pend_d;

  logic               in_win;
  logic [1:0]         sel;
  logic               wr;
  logic               ctrl_wr;
  logic               period_wr;
  logic               ack_wr;
  logic               expire;
  logic [31:0]        period_ext;
  logic [31:0]        period_mrg;
  logic               unused_addr_lsb;

  // Address decode; the byte offset within a register is irrelevant.
  assign in_win          = (addr[31:4] == BASE[31:4]);
  assign sel             = addr[3:2];
  assign wr              = in_win && (byteen != 4'b0000);
  assign ctrl_wr         = wr && (sel == 2'd0) && byteen[0];
  assign period_wr       = wr && (sel == 2'd1);
  assign ack_wr          = wr && (sel == 2'd3);
  assign expire          = (state_q == ST_RUN) && (count_q == '0);
  assign unused_addr_lsb = ^addr[1:0];
  assign state_dbg       = state_q;

  // PERIOD write: merge the enabled byte lanes over the current value.
  always_comb begin
    period_ext = 32'(period_q);
    for (int i = 0; i < 4; i++) begin
      period_mrg[8*i +: 8] = byteen[i] ? wdata[8*i +: 8] : period_ext[8*i +: 8];
    end
    period_d = period_wr ? period_mrg[CNT_W-1:0] : period_q;
  end

  // Next-state: counter FSM, PEND set/clear and CTRL update.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    mode_d  = mode_q;
    count_d = count_q;
    pend_d  = pend_q;

    // ACK first so that an expiry on the same edge wins.
    if (ack_wr) begin
      pend_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr && wdata[0]) begin
          state_d = ST_RUN;
          count_d = period_q;
        end
      end
      ST_RUN: begin
        if (expire) begin
          pend_d = 1'b1;
          if (mode_q) begin
            count_d = period_q;
          end else begin
            en_d    = 1'b0;
            state_d = ST_DONE;
          end
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (ctrl_wr && wdata[0]) begin
          state_d = ST_RUN;
          count_d = period_q;
        end else if (ack_wr) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // CTRL writes: disabling always wins and parks the counter at zero.
    if (ctrl_wr) begin
      mode_d = wdata[1];
      if (!wdata[0]) begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
        count_d = '0;
      end else if (state_q != ST_RUN) begin
        en_d = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 1'b0;
      period_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

`ifdef INT_GEN_PULSE_EN
  logic irq_q, irq_d;

  // Pulse mode: irq is high for the single cycle following an expiry edge.
  always_comb begin
    irq_d = expire;
  end

  // Pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = pend_q;
`endif

  // Read mux; anything outside the window reads zero.
  always_comb begin
    rdata = 32'h0;
    if (in_win) begin
      case (sel)
        2'd0:    rdata = {30'h0, mode_q, en_q};
        2'd1:    rdata = 32'(period_q);
        2'd2:    rdata = 32'(count_q);
        default: rdata = {31'h0, pend_q};
      endcase
    end
  end

endmodule

// File: tb/tb_int_gen_responder.sv
// Bench for int_gen_responder: register/decode vector table, hand sequences for
// one-shot, periodic, ACK/expiry collision, disable and asynchronous reset, then
// randomized traffic checked against a timestamp-based reference model.
module tb_int_gen_responder;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F20;
  localparam logic [31:0] A_PERIOD = 32'h0000_7F24;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F28;
  localparam logic [31:0] A_STAT   = 32'h0000_7F2C;
  localparam logic [31:0] A_OUT    = 32'h0000_7F30;
`ifdef INT_GEN_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  int_gen_responder dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .byteen    (byteen),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq       (irq),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- reference model ----------------
  // Time-stamped view: a running counter is just "the edge number at which it
  // fires next"; COUNT is the distance to that edge.
  longint     m_now;
  longint     m_next_fire;
  bit         m_running, m_done, m_en, m_mode, m_pend, m_fired_last;
  logic [31:0] m_period;

  task automatic model_reset();
    m_now = 0; m_next_fire = 0;
    m_running = 0; m_done = 0; m_en = 0; m_mode = 0; m_pend = 0; m_fired_last = 0;
    m_period = 32'h0;
  endtask

  task automatic model_edge(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bit win, w, fire, done_old, run_old;
    logic [31:0] p_old;
    m_now++;
    win = (a[31:4] == A_CTRL[31:4]);
    w = win && (be != 4'b0000);
    p_old = m_period;
    done_old = m_done;
    run_old = m_running;
    fire = m_running && (m_now == m_next_fire);
    m_fired_last = fire;
    if (fire) begin
      m_pend = 1;
      if (m_mode) m_next_fire = m_now + longint'(p_old) + 1;
      else begin m_running = 0; m_done = 1; m_en = 0; end
    end
    if (w && a[3:2] == 2'd3) begin
      if (!fire) m_pend = 0;
      if (done_old) m_done = 0;
    end
    if (w && a[3:2] == 2'd0 && be[0]) begin
      m_mode = d[1];
      if (!d[0]) begin
        m_running = 0; m_done = 0; m_en = 0;
      end else if (!run_old) begin
        m_running = 1; m_done = 0; m_en = 1;
        m_next_fire = m_now + longint'(p_old) + 1;
      end
    end
    if (w && a[3:2] == 2'd1) begin
      for (int i = 0; i < 4; i++) if (be[i]) m_period[8*i +: 8] = d[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] s);
    case (s)
      2'd0:    return {30'h0, m_mode, m_en};
      2'd1:    return m_period;
      2'd2:    return m_running ? 32'(m_next_fire - 1 - m_now) : 32'h0;
      default: return {31'h0, m_pend};
    endcase
  endfunction

  function automatic logic [1:0] model_state();
    return m_running ? 2'd1 : (m_done ? 2'd2 : 2'd0);
  endfunction

  function automatic logic model_irq();
    return PULSE ? m_fired_last : m_pend;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle with the given bus write (byteen=0 means no write).
  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    addr = a; byteen = be; wdata = d;
    @(posedge clk);
    model_edge(a, be, d);
    #1;
    byteen = 4'b0000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) wr(A_CTRL, 4'b0000, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; byteen = 4'b0000;
    #1;
    d = rdata;
  endtask

  task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(name, v, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] ra;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[9];

  initial begin
    logic [31:0] v;
    bit irq_seen;
    int op;
    logic [1:0] s;

    vecs[0] = '{A_PERIOD, 4'b1111, 32'h1122_3344, A_PERIOD, 32'h1122_3344};
    vecs[1] = '{A_PERIOD, 4'b0010, 32'h0000_AB00, A_PERIOD, 32'h1122_AB44};
    vecs[2] = '{A_OUT,    4'b1111, 32'hFFFF_FFFF, A_PERIOD, 32'h1122_AB44};
    vecs[3] = '{A_OUT,    4'b1111, 32'h0000_0003, A_OUT,    32'h0000_0000};
    vecs[4] = '{A_PERIOD, 4'b0000, 32'h0000_0000, A_PERIOD, 32'h1122_AB44};
    vecs[5] = '{A_CTRL,   4'b0000, 32'h0000_0003, A_CTRL,   32'h0000_0000};
    vecs[6] = '{A_COUNT,  4'b1111, 32'h0000_0055, A_COUNT,  32'h0000_0000};
    vecs[7] = '{A_CTRL,   4'b1110, 32'h0000_0003, A_CTRL,   32'h0000_0000};
    vecs[8] = '{A_PERIOD, 4'b1100, 32'h0000_0000, A_PERIOD, 32'h0000_AB44};

    // Reset with garbage on the bus.
    reset = 1'b0; addr = A_CTRL; byteen = 4'b1111; wdata = $urandom;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chk("reset_state", {30'h0, state_dbg}, 32'h0);
    addr = A_CTRL;   #1; chk("reset_ctrl", rdata, 32'h0);
    addr = A_PERIOD; #1; chk("reset_period", rdata, 32'h0);
    addr = A_COUNT;  #1; chk("reset_count", rdata, 32'h0);
    addr = A_STAT;   #1; chk("reset_stat", rdata, 32'h0);
    byteen = 4'b0000;
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Register and decode vectors.
    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].a, vecs[i].be, vecs[i].d);
      rd(vecs[i].ra, v);
      chk($sformatf("vec%0d_rdata", i), v, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'h0, irq}, 32'h0);
      chk($sformatf("vec%0d_state", i), {30'h0, state_dbg}, 32'h0);
    end

    // One-shot, PERIOD=5.
    wr(A_PERIOD, 4'b1111, 32'd5);
    wr(A_CTRL, 4'b0001, 32'h1);
    chk_reg("os_count5", A_COUNT, 32'd5);
    for (int k = 4; k >= 0; k--) begin
      idle(1);
      chk_reg($sformatf("os_count%0d", k), A_COUNT, 32'(k));
      chk("os_irq_low", {31'h0, irq}, 32'h0);
    end
    idle(1);
    chk("os_irq_rise", {31'h0, irq}, 32'h1);
    chk_reg("os_ctrl_after", A_CTRL, 32'h0);
    chk_reg("os_stat", A_STAT, 32'h1);
    chk("os_state_done", {30'h0, state_dbg}, 32'h2);
    idle(1);
    chk("os_irq_after", {31'h0, irq}, PULSE ? 32'h0 : 32'h1);
    chk_reg("os_stat_held", A_STAT, 32'h1);
    chk("os_still_done", {30'h0, state_dbg}, 32'h2);
    wr(A_STAT, 4'b0001, 32'h0);
    chk("os_ack_irq", {31'h0, irq}, 32'h0);
    chk_reg("os_ack_stat", A_STAT, 32'h0);
    chk("os_ack_idle", {30'h0, state_dbg}, 32'h0);
    wr(A_CTRL, 4'b0001, 32'h1);
    idle(5);
    chk("os2_irq_low", {31'h0, irq}, 32'h0);
    idle(1);
    chk("os2_irq_rise", {31'h0, irq}, 32'h1);
    wr(A_STAT, 4'b1000, 32'h0);
    chk_reg("os2_ack_stat", A_STAT, 32'h0);

    // Periodic, PERIOD=2: fires every 3 edges.
    wr(A_PERIOD, 4'b1111, 32'd2);
    wr(A_CTRL, 4'b0001, 32'h3);
    idle(2);
    chk("per_irq_t2", {31'h0, irq}, 32'h0);
    idle(1);
    chk("per_irq_t3", {31'h0, irq}, 32'h1);
    idle(2);
    chk("per_irq_t5", {31'h0, irq}, PULSE ? 32'h0 : 32'h1);
    idle(1);
    chk("per_irq_t6", {31'h0, irq}, 32'h1);
    chk_reg("per_stat_t6", A_STAT, 32'h1);
    for (int r = 0; r < 3; r++) begin
      wr(A_STAT, 4'b0001, 32'h0);
      chk($sformatf("per_ack%0d_irq", r), {31'h0, irq}, 32'h0);
      chk_reg($sformatf("per_ack%0d_stat", r), A_STAT, 32'h0);
      idle(1);
      chk($sformatf("per_gap%0d_irq", r), {31'h0, irq}, 32'h0);
      idle(1);
      chk($sformatf("per_refire%0d_irq", r), {31'h0, irq}, 32'h1);
    end
    wr(A_CTRL, 4'b0001, 32'h0);
    chk("per_dis_state", {30'h0, state_dbg}, 32'h0);
    chk_reg("per_dis_pend_kept", A_STAT, 32'h1);
    chk_reg("per_dis_count", A_COUNT, 32'h0);
    wr(A_STAT, 4'b0001, 32'h0);

    // Same-edge ACK and expiry, PERIOD=0 periodic.
    wr(A_PERIOD, 4'b1111, 32'd0);
    wr(A_CTRL, 4'b0001, 32'h3);
    wr(A_STAT, 4'b0001, 32'h0);
    chk_reg("coll_stat", A_STAT, 32'h1);
    chk("coll_irq", {31'h0, irq}, 32'h1);
    wr(A_CTRL, 4'b0001, 32'h0);
    wr(A_STAT, 4'b0001, 32'h0);
    chk_reg("coll_ack_stat", A_STAT, 32'h0);

    // Disable mid-count, PERIOD=100.
    wr(A_PERIOD, 4'b1111, 32'd100);
    wr(A_CTRL, 4'b0001, 32'h1);
    idle(10);
    chk_reg("dis_count90", A_COUNT, 32'd90);
    wr(A_CTRL, 4'b0001, 32'h0);
    chk_reg("dis_count0", A_COUNT, 32'h0);
    chk("dis_state", {30'h0, state_dbg}, 32'h0);
    irq_seen = 0;
    for (int i = 0; i < 120; i++) begin
      idle(1);
      irq_seen |= irq;
    end
    chk("dis_no_irq", {31'h0, irq_seen}, 32'h0);

    // Asynchronous reset mid-count with irq already raised (level build).
    wr(A_PERIOD, 4'b1111, 32'd3);
    wr(A_CTRL, 4'b0001, 32'h3);
    idle(6);
    chk_reg("arst_pre_stat", A_STAT, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("arst_irq", {31'h0, irq}, 32'h0);
    chk("arst_state", {30'h0, state_dbg}, 32'h0);
    addr = A_CTRL;   #1; chk("arst_ctrl", rdata, 32'h0);
    addr = A_PERIOD; #1; chk("arst_period", rdata, 32'h0);
    addr = A_COUNT;  #1; chk("arst_count", rdata, 32'h0);
    addr = A_STAT;   #1; chk("arst_stat", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int c = 0; c < 700; c++) begin
      op = $urandom_range(0, 15);
      case (op)
        0, 1:   wr(A_PERIOD, 4'($urandom_range(1, 15)), 32'($urandom_range(0, 9)));
        2, 3:   if (!m_running) wr(A_CTRL, 4'b0001 | 4'($urandom_range(0, 15)),
                                   {30'h0, 1'($urandom_range(0, 1)), 1'b1});
                else idle(1);
        4, 5:   wr(A_STAT, 4'($urandom_range(1, 15)), $urandom);
        6:      wr(A_OUT + 32'($urandom_range(0, 3) * 4), 4'b1111, $urandom);
        7:      wr(A_CTRL + 32'($urandom_range(0, 3) * 4), 4'b0000, $urandom);
        8:      wr(A_CTRL, 4'b1110, 32'h3);
        9:      wr(A_COUNT, 4'b1111, $urandom);
        15:     wr(A_CTRL, 4'b0001, {30'h0, 1'($urandom_range(0, 1)), 1'b0});
        default: idle(1);
      endcase
      s = 2'($urandom_range(0, 3));
      exp_q.push_back(model_read(s));
      rd(A_CTRL + 32'(s) * 4, v);
      chk($sformatf("rnd_rd_sel%0d", s), v, exp_q.pop_front());
      chk("rnd_irq", {31'h0, irq}, {31'h0, model_irq()});
      chk("rnd_state", {30'h0, state_dbg}, {30'h0, model_state()});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_gen_responder.md
Name: int_gen_responder

Overview:
- Bus-responder peripheral on the bridge's interrupt-generator port: accepts CPU stores (address + byte enables) and raises an interrupt line into HWInt[2] after a programmed delay.
- Supports one-shot and periodic modes. Pending state is held until the CPU acknowledges it with a store.
- It is the device end of the write-only interrupt-generator channel that the bridge drives, plus a read-back path for the bridge's read mux.

Parameters:
- BASE, 32'h0000_7F20, byte address of register 0; the window is BASE..BASE+0xF.
- CNT_W, 32, width of PERIOD and COUNT; must be between 1 and 32.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0). Clears all state immediately, independent of clk.
- addr  in  32  byte address from the bridge (m_int_addr side).
- byteen  in  4  byte-lane write enables. A write occurs when byteen != 0 and addr[31:4] == BASE[31:4].
- wdata  in  32  store data, byte-lane aligned.
- rdata  out  32  combinational read of the register selected by addr[3:2]; reads 0 outside the window.
- irq  out  1  interrupt request to the CPU.

Behaviour:
- Register map (addr[3:2]):
  - 0 = CTRL: bit0 EN, bit1 MODE (0 one-shot, 1 periodic); other bits read 0.
  - 1 = PERIOD: R/W, CNT_W bits.
  - 2 = COUNT: read-only; writes ignored.
  - 3 = STAT/ACK: bit0 PEND on read; any write with byteen != 0 clears PEND.
- Writes to CTRL and PERIOD honour byteen per lane. Lanes above CNT_W are ignored.
- Reset values: CTRL=0, PERIOD=0, COUNT=0, PEND=0, state=IDLE, irq=0. rdata reflects these values.
- FSM:
  - IDLE: a write that sets EN=1 moves to RUN; COUNT <= PERIOD, where PERIOD is the value before this edge's write. If PERIOD and CTRL are written in the same cycle, the old PERIOD is loaded.
  - RUN:
    - COUNT != 0: decrement each cycle.
    - COUNT == 0: expiry. PEND <= 1.
      - Periodic: COUNT <= PERIOD, stay in RUN.
      - One-shot: EN <= 0, go to DONE.
  - DONE: wait for ACK; ACK clears PEND and returns to IDLE. A write setting EN=1 while in DONE goes to RUN and leaves PEND unchanged.
  - Any state: a write of EN=0 returns to IDLE next edge and clears COUNT. PEND is kept.
- Latency: the enabling write at edge t produces PEND=1 at edge t+PERIOD+1. PERIOD=0 fires one cycle after enable.
- Periodic interval is PERIOD+1 cycles.
- Simultaneous ACK and expiry: expiry wins, PEND stays 1.
- Writing PERIOD during RUN has no effect on the current COUNT; the new value applies at the next load.
- COUNT never wraps: the decrement stops at 0 because of the expiry rule.
- irq = PEND (level) by default.
- Reset asserted mid-count drops irq and all state immediately (asynchronously).

Optional Feature:
- Macro INT_GEN_PULSE_EN.
- When defined: irq is a single-cycle pulse, high for the one cycle after each expiry edge. PEND is still set and readable, and ACK is still needed to leave DONE.
- When undefined: irq follows PEND (level, held until ACK).

Test Plan:
- Reset: reset=0 with garbage on the bus -> irq=0, and every register reads 0 at 0x7F20..0x7F2C.
- One-shot:
  - Stimulus: PERIOD=5; CTRL=0x1 at edge t.
  - Required: COUNT reads 5,4,3,2,1,0; irq rises at t+6; CTRL reads 0; state DONE.
  - Then write 0x7F2C with byteen=4'b0001 -> irq=0 next cycle; a later enable works.
- Periodic:
  - Stimulus: PERIOD=2; CTRL=0x3; do not ACK.
  - Required: irq rises at t+3 and stays high. Then ACK every 3 cycles -> irq re-asserts every 3 cycles.
- Same-cycle ACK and expiry, periodic PERIOD=0 -> PEND remains 1. Byte-lane write of PERIOD with byteen=4'b0010, data 0x0000AB00 over 0x11223344 -> reads 0x1122AB44.
- Disable mid-count: PERIOD=100, enable, write CTRL=0 after 10 cycles -> COUNT=0, irq never rises. Mid-count reset=0 -> irq=0 asynchronously and all registers read 0.
- Window decode: writes to 0x7F30 and to 0x7F20 with byteen=0 -> no state change. With INT_GEN_PULSE_EN, PERIOD=3 one-shot -> irq high for exactly 1 cycle while STAT reads 1.
